// File: rtl/fdivsqrt_iter_ctrl.sv
// Iteration controller for the radix-4 divide/sqrt recurrence: IDLE/BUSY/DONE sequencing and per-cycle strobes.
// Optional macro FDIVSQRT_EARLY_TERM_EN ends the recurrence as soon as the residual is zero.
module fdivsqrt_iter_ctrl #(
    parameter int ITERW = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             FlushE,
    input  logic             StallM,
    input  logic             DivStartE,
    input  logic             SqrtE,
    input  logic             SpecialCaseE,
    input  logic [ITERW-1:0] IterCntE,
    input  logic             WZeroE,
    output logic             IFDivStartE,
    output logic             IterEn,
    output logic             j1,
    output logic             jlast,
    output logic             SqrtLatched,
    output logic             DivBusyE,
    output logic             FDivDoneE
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           r_state;
    logic [ITERW-1:0] r_cnt;
    logic             r_sqrt;
    logic             r_j1;

    logic w_idle, w_busy, w_done;
    logic w_start, w_last, w_early;

    assign w_idle = (r_state == IDLE);
    assign w_busy = (r_state == BUSY);
    assign w_done = (r_state == DONE);

`ifdef FDIVSQRT_EARLY_TERM_EN
    // A zero residual on the first iteration is still the seed value, so only later cycles may stop early.
    assign w_early = WZeroE & ~r_j1;
`else
    logic w_unused;
    assign w_unused = WZeroE;
    assign w_early  = 1'b0;
`endif

    // Reset gates the start so no output can assert while reset is held.
    assign w_start = DivStartE & ~FlushE & w_idle & ~reset;
    assign w_last  = w_busy & ((r_cnt == ITERW'(1)) | w_early);

    assign IFDivStartE = w_start;
    assign IterEn      = w_busy & ~FlushE;
    assign j1          = w_busy & r_j1 & ~FlushE;
    assign jlast       = w_last;
    assign SqrtLatched = r_sqrt;
    assign DivBusyE    = w_busy | (w_done & StallM);
    assign FDivDoneE   = w_done;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_sqrt  <= 1'b0;
            r_j1    <= 1'b0;
        end else begin
            r_j1 <= w_start & ~SpecialCaseE;
            if (FlushE) begin
                r_state <= IDLE;
                r_cnt   <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_start) begin
                            r_sqrt <= SqrtE;
                            if (SpecialCaseE) begin
                                r_state <= DONE;
                            end else begin
                                r_state <= BUSY;
                                r_cnt   <= (IterCntE == '0) ? ITERW'(1) : IterCntE;
                            end
                        end
                    end
                    BUSY: begin
                        // Clearing on the last cycle keeps the counter from wrapping after an early stop.
                        if (w_last) begin
                            r_state <= DONE;
                            r_cnt   <= '0;
                        end else begin
                            r_cnt <= r_cnt - ITERW'(1);
                        end
                    end
                    DONE: begin
                        if (!StallM) begin
                            r_state <= IDLE;
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/fdivsqrt_iter_ctrl.md
FDIVSQRT_ITER_CTRL -- requirements
Module: fdivsqrt_iter_ctrl

Interface
REQ-001 The module SHALL have parameter ITERW, default 6, giving the width of the iteration counter.
REQ-002 The module SHALL have these ports, in this order:
- clk  input  1  single clock; all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- FlushE  input  1  pipeline flush; aborts any operation.
- StallM  input  1  downstream stall; holds result in DONE.
- DivStartE  input  1  request to start a divide/sqrt.
- SqrtE  input  1  1 = sqrt, 0 = divide; sampled at accept.
- SpecialCaseE  input  1  NaN/Inf/zero operand; no iterations needed.
- IterCntE  input  ITERW  radix-4 iterations required; sampled at accept.
- WZeroE  input  1  residual-is-zero flag from the recurrence.
- IFDivStartE  output  1  start accepted this cycle; loads the initial residual, U, UM and C.
- IterEn  output  1  recurrence registers update this cycle.
- j1  output  1  first iteration cycle.
- jlast  output  1  final iteration cycle.
- SqrtLatched  output  1  operation type held for the whole operation.
- DivBusyE  output  1  unit occupied; stalls the E stage.
- FDivDoneE  output  1  result valid.

Function
REQ-003 The controller SHALL implement states IDLE, BUSY and DONE, held in a registered state and a registered down-counter Cnt[ITERW-1:0].
REQ-004 IFDivStartE SHALL be the combinational value DivStartE & ~FlushE & (state==IDLE).
- A start requested in BUSY or DONE SHALL be ignored.
REQ-005 On accept, the controller SHALL latch SqrtLatched from SqrtE.
- With SpecialCaseE=1: the next state SHALL be DONE.
- Otherwise: the next state SHALL be BUSY and Cnt SHALL load max(IterCntE,1).
REQ-006 In BUSY:
- IterEn SHALL be 1.
- Cnt SHALL decrement by 1 each cycle.
- jlast SHALL equal (Cnt==1).
- When jlast=1 the next state SHALL be DONE.
REQ-007 j1 SHALL be 1 only in the first BUSY cycle after an accept.
- It SHALL be registered from IFDivStartE & ~SpecialCaseE.
REQ-008 For IterCntE=N (N>=1), there SHALL be exactly N IterEn cycles.
- j1 SHALL be on the first of these cycles and jlast on the last.
- When N=1, j1 and jlast SHALL both be 1 in the same cycle.
REQ-009 In DONE:
- FDivDoneE SHALL be 1.
- IterEn SHALL be 0.
- The state SHALL remain DONE while StallM=1.
- The state SHALL go to IDLE on the first cycle with StallM=0.
REQ-010 DivBusyE SHALL equal (state==BUSY) | (state==DONE & StallM).
REQ-011 FlushE=1 in any state SHALL force the next state to IDLE.
- In that same cycle IterEn, IFDivStartE and j1 SHALL be 0.
- Flush SHALL take priority over start, completion and early termination.
REQ-012 In IDLE, IterEn, j1, jlast, DivBusyE and FDivDoneE SHALL all be 0.
REQ-013 Cnt SHALL never wrap.
- A decrement from 1 SHALL coincide with the transition out of BUSY.
- IterCntE=0 SHALL be treated as 1.

Reset
REQ-014 While reset=1, on each clock edge the state SHALL go to IDLE and Cnt, SqrtLatched and the j1 register SHALL clear to 0.
- Reset SHALL take priority over FlushE and DivStartE.
REQ-015 While reset=1, all outputs SHALL be 0 from the next cycle onward.
REQ-016 Reset asserted during BUSY or DONE SHALL abandon the operation; no FDivDoneE pulse SHALL follow.

Configuration
REQ-017 With macro FDIVSQRT_EARLY_TERM_EN defined:
- In BUSY with WZeroE=1 and j1=0, the next state SHALL be DONE.
- jlast SHALL be asserted in that cycle.
- This SHALL apply even if Cnt>1.
REQ-018 Without FDIVSQRT_EARLY_TERM_EN:
- WZeroE SHALL be ignored; the port remains present.
- The operation SHALL always run the full count.

Verification
REQ-019 The bench SHALL cover these directed scenarios:
- Divide, IterCntE=14, StallM=0:
  - IFDivStartE=1 in cycle 0.
  - IterEn=1 in cycles 1-14; j1 in cycle 1; jlast in cycle 14.
  - FDivDoneE=1 in cycle 15; IDLE in cycle 16.
- SpecialCaseE=1, IterCntE=14:
  - No IterEn; FDivDoneE=1 in cycle 1.
- IterCntE=1 and IterCntE=0:
  - Exactly one IterEn cycle, with j1=jlast=1.
  - DONE on the following cycle.
- StallM=1 for 3 cycles on reaching DONE:
  - FDivDoneE and DivBusyE stay 1 for 3 cycles.
  - A DivStartE during this time is ignored; IDLE follows StallM=0.
- FlushE in the 5th BUSY cycle, then reset in the 3rd BUSY cycle of a new operation:
  - IDLE next cycle each time; no FDivDoneE pulse.
  - A new start is accepted one cycle later.
- Early termination, IterCntE=14, WZeroE=1 in BUSY cycle 6:
  - With FDIVSQRT_EARLY_TERM_EN: jlast in cycle 6, DONE in cycle 7.
  - Without it: all 14 iterations run.
